// File: rtl/window_scan_ctrl_pkg.sv
// Shared types and limits for the 3x3 raster window scan controller.
package window_scan_ctrl_pkg;

    localparam int PIX_W        = 8;
    localparam int IMG_DIM_MIN  = 3;
    localparam int IMG_DIM_MAX  = 1024;
    localparam int PIPE_LAT_MIN = 1;
    localparam int PIPE_LAT_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/window_scan_ctrl_line_buffer2.sv
// Two-row line store: one word per column holds the pixels one and two rows back.
module line_buffer2
    import window_scan_ctrl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] tap1,
    output logic [PIX_W-1:0] tap2
);

    logic [2*PIX_W-1:0] mem_q [DEPTH];

    // Writing pushes the one-row-back pixel into the two-rows-back slot.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= {mem_q[addr][PIX_W-1:0], din};
        end
    end

    assign tap1 = mem_q[addr][PIX_W-1:0];
    assign tap2 = mem_q[addr][2*PIX_W-1:PIX_W];

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scan 3x3 window generator with border replication and a
// downstream-latency valid tracker.
module window_scan_ctrl
    import window_scan_ctrl_pkg::*;
#(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    output logic [PIX_W-1:0] p9,
    output logic             win_valid,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H + 2);
    localparam int ACC_W = $clog2(IMG_W * IMG_H + 1);
    localparam int FL_W  = $clog2(IMG_W + 2);
    localparam int DR_W  = $clog2(PIPE_LAT + 3);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(IMG_W * IMG_H - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(IMG_W);
    localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(PIPE_LAT + 1);

    if (IMG_W < IMG_DIM_MIN || IMG_W > IMG_DIM_MAX) begin : g_bad_img_w
        $error("IMG_W out of range");
    end
    if (IMG_H < IMG_DIM_MIN || IMG_H > IMG_DIM_MAX) begin : g_bad_img_h
        $error("IMG_H out of range");
    end
    if (PIPE_LAT < PIPE_LAT_MIN || PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_lat
        $error("PIPE_LAT out of range");
    end

    state_t              state_q, state_d;
    logic [COL_W-1:0]    wc_q, wc_d;
    logic [ROW_W-1:0]    wr_q, wr_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FL_W-1:0]     fcnt_q, fcnt_d;
    logic [DR_W-1:0]     dcnt_q, dcnt_d;
    logic [PIX_W-1:0]    win_q [9];
    logic [PIX_W-1:0]    win_d [9];
    logic                win_valid_q, win_valid_d;
    logic                top_q, top_d, bot_q, bot_d;
    logic                lft_q, lft_d, rgt_q, rgt_d;
    logic [PIPE_LAT-1:0] ov_q, ov_d;

    logic                xfer, shift, cen_ok;
    logic [ROW_W-1:0]    crow;
    logic [COL_W-1:0]    ccol;
    logic [PIX_W-1:0]    tap1, tap2, shift_pix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (xfer && acc_q == ACC_LAST) state_d = ST_FLUSH;
            ST_FLUSH: if (fcnt_q == FL_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (dcnt_q == DR_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_ready  = 1'b0;
        busy       = 1'b1;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE:  busy = 1'b0;
            ST_RUN:   pix_ready = 1'b1;
            ST_DRAIN: frame_done = (dcnt_q == DR_LAST);
            default:  ;
        endcase
    end

    assign xfer      = pix_ready && pix_valid;
    assign shift     = xfer || (state_q == ST_FLUSH);
    assign shift_pix = xfer ? pix_in : '0;

    always_comb begin
        wc_d   = wc_q;
        wr_d   = wr_q;
        acc_d  = acc_q;
        fcnt_d = fcnt_q;
        dcnt_d = dcnt_q;
        if (state_q == ST_IDLE && start) begin
            wc_d   = '0;
            wr_d   = '0;
            acc_d  = '0;
            fcnt_d = '0;
            dcnt_d = '0;
        end
        // wc/wr track the raster position of the pixel being shifted in, dummies included.
        if (shift) begin
            if (wc_q == COL_LAST) begin
                wc_d = '0;
                wr_d = wr_q + ROW_W'(1);
            end else begin
                wc_d = wc_q + COL_W'(1);
            end
        end
        if (xfer)                 acc_d  = acc_q + ACC_W'(1);
        if (state_q == ST_FLUSH)  fcnt_d = fcnt_q + FL_W'(1);
        if (state_q == ST_DRAIN)  dcnt_d = dcnt_q + DR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wc_q   <= '0;
            wr_q   <= '0;
            acc_q  <= '0;
            fcnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            wc_q   <= wc_d;
            wr_q   <= wr_d;
            acc_q  <= acc_d;
            fcnt_q <= fcnt_d;
            dcnt_q <= dcnt_d;
        end
    end

    line_buffer2 #(.DEPTH(IMG_W)) u_lbuf (
        .clk  (clk),
        .we   (shift),
        .addr (wc_q),
        .din  (shift_pix),
        .tap1 (tap1),
        .tap2 (tap2)
    );

    // Centre sits IMG_W+1 raster positions behind the pixel being shifted in.
    assign crow   = (wc_q == '0) ? wr_q - ROW_W'(2) : wr_q - ROW_W'(1);
    assign ccol   = (wc_q == '0) ? COL_LAST : wc_q - COL_W'(1);
    assign cen_ok = (wr_q > ROW_W'(1)) || (wr_q == ROW_W'(1) && wc_q != '0);

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_d[i] = win_q[i];
        end
        win_valid_d = 1'b0;
        top_d = top_q;
        bot_d = bot_q;
        lft_d = lft_q;
        rgt_d = rgt_q;
        if (shift) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = tap2;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = tap1;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = shift_pix;
            if (cen_ok) begin
                win_valid_d = 1'b1;
                top_d = (crow == '0);
                bot_d = (crow == ROW_LAST);
                lft_d = (ccol == '0);
                rgt_d = (ccol == COL_LAST);
            end
        end
    end

    always_comb begin
        ov_d    = ov_q;
        ov_d[0] = win_valid_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            ov_d[i] = ov_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
            win_valid_q <= 1'b0;
            top_q       <= 1'b0;
            bot_q       <= 1'b0;
            lft_q       <= 1'b0;
            rgt_q       <= 1'b0;
            ov_q        <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
            win_valid_q <= win_valid_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            lft_q       <= lft_d;
            rgt_q       <= rgt_d;
            ov_q        <= ov_d;
        end
    end

    // Out-of-image taps replicate the centre; this also hides wrapped and stale data.
    assign p1 = (top_q || lft_q) ? win_q[4] : win_q[0];
    assign p2 = top_q            ? win_q[4] : win_q[1];
    assign p3 = (top_q || rgt_q) ? win_q[4] : win_q[2];
    assign p4 = lft_q            ? win_q[4] : win_q[3];
    assign p5 = win_q[4];
    assign p6 = rgt_q            ? win_q[4] : win_q[5];
    assign p7 = (bot_q || lft_q) ? win_q[4] : win_q[6];
    assign p8 = bot_q            ? win_q[4] : win_q[7];
    assign p9 = (bot_q || rgt_q) ? win_q[4] : win_q[8];

    assign win_valid = win_valid_q;
    assign out_valid = ov_q[PIPE_LAT-1];

endmodule

// File: doc/window_scan_ctrl.md
WINDOW_SCAN_CTRL -- requirements
Module: window_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 64, pixels per row; legal range 3..1024.
REQ-002 Parameter IMG_H, default 64, rows per frame; legal range 3..1024.
REQ-003 Parameter PIPE_LAT, default 4, cycle latency of the downstream difference/filter pipeline; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; starts a frame; honoured only in IDLE.
REQ-007 pix_in  input  8  raster-order input pixel.
REQ-008 pix_valid  input  1  pix_in is valid this cycle.
REQ-009 pix_ready  output  1  controller accepts pix_in this cycle; a transfer occurs when pix_valid and pix_ready are both high.
REQ-010 p1..p9  output  8 each  3x3 window, p1..p3 top row, p5 centre, p7..p9 bottom row, left to right.
REQ-011 win_valid  output  1  p1..p9 hold a valid window this cycle.
REQ-012 out_valid  output  1  win_valid delayed by exactly PIPE_LAT cycles; qualifies downstream results.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, FLUSH, DRAIN.
REQ-016 IDLE: pix_ready=0; start -> RUN, clear row/column/accept counters.
REQ-017 RUN: pix_ready=1; each transfer writes pix_in into the two-line buffer and shifts the 3x3 register array one column.
REQ-018 RUN -> FLUSH in the cycle after the (IMG_W*IMG_H)th transfer.
REQ-019 FLUSH: pix_ready=0; the window shifts once per cycle with a dummy pixel for exactly IMG_W+1 cycles; then -> DRAIN.
REQ-020 DRAIN: wait PIPE_LAT cycles; frame_done pulses in the cycle after the last out_valid; then -> IDLE.
REQ-021 The window centre SHALL lag the newest shifted pixel by IMG_W+1 raster positions; win_valid is high for the shift that places centre (r,c) in p5, for every r<IMG_H, c<IMG_W.
REQ-022 Exactly IMG_W*IMG_H win_valid cycles and IMG_W*IMG_H out_valid cycles SHALL occur per frame, in raster order of centre.
REQ-023 Border rule: any window position outside the image (row -1, row IMG_H, column -1, column IMG_W) SHALL output the p5 value, so its absolute difference to the centre is 0.
REQ-024 A window SHALL never contain pixels wrapped from the opposite image edge or from a previous frame.
REQ-025 pix_valid low in RUN SHALL stall all shifting; win_valid is low during stalls; no state advances.
REQ-026 start outside IDLE SHALL be ignored.
REQ-027 Counters SHALL be sized ceil(log2(max+1)); column counter wraps IMG_W-1 -> 0 and increments row.

Reset
REQ-028 While rst=0: state=IDLE, all counters=0, p1..p9=0, win_valid=0, out_valid pipeline=0, pix_ready=0, busy=0, frame_done=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no frame_done; the next frame after release starts only on a new start.
REQ-030 Line-buffer contents need not be reset; REQ-023/024 masking guarantees they are never observed.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, pixel width constant (8) and parameter range limits.
REQ-032 The two-row storage SHALL be one sub-module, line_buffer2 (depth IMG_W, two 8-bit taps, single write port).
REQ-033 Counters, FSM, 3x3 register array, border mux and PIPE_LAT valid shift register reside in window_scan_ctrl.

Verification (IMG_W=4, IMG_H=4, PIPE_LAT=4 unless stated)
REQ-034 Reset then start, pixels 1..16 streamed without gaps -> 16 win_valid; first window p1..p9 = 1,1,1,1,1,2,1,5,6; frame_done 1 cycle after 16th out_valid.
REQ-035 Same stream, centre pixel 16 (r3,c3) -> p1..p9 = 11,12,16,15,16,16,16,16,16.
REQ-036 pix_valid toggled 1/0 every cycle -> identical 16 window contents as REQ-034, no win_valid during stalls, pix_ready=1 throughout RUN.
REQ-037 start pulsed in RUN at pixel 5 -> ignored; frame completes normally with 16 windows.
REQ-038 rst pulled low after 9 transfers -> all outputs 0 asynchronously, no frame_done; new start with pixels 101..116 -> first window centre 101, no pixel from aborted frame appears.
REQ-039 Back-to-back frames, start issued the cycle after frame_done -> second frame windows contain only second-frame pixels, border values equal p5.
